// File: rtl/crc_serial_if.sv
// Handshake and result bundle for crc_serial_engine; master = packet source, slave = engine.
interface crc_serial_if #(
  parameter int DATA_W = 8,
  parameter int CRC_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic              busy;
  logic              crc_valid;
  logic [CRC_W-1:0]  crc_out;
  logic [CRC_W-1:0]  crc_running;

  modport master (
    output in_valid, in_data, in_sop, in_eop,
    input  in_ready, busy, crc_valid, crc_out, crc_running
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop,
    output in_ready, busy, crc_valid, crc_out, crc_running
  );
endinterface

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC engine: one data bit per clock into a CRC_W-bit LFSR, frames delimited by sop/eop.
// Optional CRC_SERIAL_REFLECT_EN: LSB-first data and bit-reversed crc_out (crc_running stays raw).
module crc_serial_engine #(
  parameter int               CRC_W   = 16,
  parameter int               DATA_W  = 8,
  parameter logic [CRC_W-1:0] POLY    = 16'h1021,
  parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_n,
  crc_serial_if.slave  bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q;
  logic [CRC_W-1:0]  lfsr_q;
  logic [CRC_W-1:0]  crc_out_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              eop_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              crc_valid_q;

  logic              data_bit;
  logic              fb;
  logic              accept;
  logic [CRC_W-1:0]  lfsr_d;
  logic [CRC_W-1:0]  crc_final_d;
  logic [DATA_W-1:0] shift_d;

`ifdef CRC_SERIAL_REFLECT_EN
  logic [CRC_W-1:0] lfsr_rev_d;

  assign data_bit = shift_q[0];
  assign shift_d  = shift_q >> 1;
  for (genvar gi = 0; gi < CRC_W; gi++) begin : g_rev
    assign lfsr_rev_d[gi] = lfsr_d[CRC_W-1-gi];
  end
  assign crc_final_d = lfsr_rev_d ^ XOR_OUT;
`else
  assign data_bit    = shift_q[DATA_W-1];
  assign shift_d     = shift_q << 1;
  assign crc_final_d = lfsr_d ^ XOR_OUT;
`endif

  assign fb     = lfsr_q[CRC_W-1] ^ data_bit;
  assign lfsr_d = {lfsr_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  assign accept = bus.in_valid & in_ready_q;

  // in_ready/busy are registered, so they come up one clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= INIT;
      crc_out_q   <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      eop_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          if (accept) begin
            shift_q    <= bus.in_data;
            cnt_q      <= CNT_W'(DATA_W - 1);
            eop_q      <= bus.in_eop;
            if (bus.in_sop) lfsr_q <= INIT;
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          lfsr_q  <= lfsr_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            if (eop_q) begin
              state_q     <= DONE;
              crc_out_q   <= crc_final_d;
              crc_valid_q <= 1'b1;
            end else begin
              state_q    <= IDLE;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end
          end
        end
        DONE: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.busy        = busy_q;
  assign bus.crc_valid   = crc_valid_q;
  assign bus.crc_out     = crc_out_q;
  assign bus.crc_running = lfsr_q;
endmodule

// File: tb/tb_crc_serial_engine.sv
// Self-checking bench for crc_serial_engine: three instances (CRC-16 INIT=FFFF, CRC-16 INIT=0, CRC-32 with 1-bit words).
module tb_crc_serial_engine;
`ifdef CRC_SERIAL_REFLECT_EN
  localparam bit REFLECT = 1'b1;
`else
  localparam bit REFLECT = 1'b0;
`endif
  localparam logic [15:0] POLY16 = 16'h1021;
  localparam logic [15:0] INIT_A = 16'hFFFF;
  localparam logic [15:0] INIT_B = 16'h0000;
  localparam logic [15:0] XOR16  = 16'h0000;
  localparam logic [31:0] POLY32 = 32'h04C11DB7;
  localparam logic [31:0] INIT_C = 32'hFFFFFFFF;
  localparam logic [31:0] XOR_C  = 32'hFFFFFFFF;
  localparam logic [15:0] K_A = REFLECT ? 16'h6F91 : 16'h29B1;
  localparam logic [15:0] K_B = REFLECT ? 16'h2189 : 16'h31C3;
  localparam logic [31:0] K_C = REFLECT ? 32'hCBF43926 : 32'hFC891918;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc_serial_if #(.DATA_W(8), .CRC_W(16)) bus_a ();
  crc_serial_if #(.DATA_W(8), .CRC_W(16)) bus_b ();
  crc_serial_if #(.DATA_W(1), .CRC_W(32)) bus_c ();

  crc_serial_engine #(.CRC_W(16), .DATA_W(8), .POLY(POLY16), .INIT(INIT_A), .XOR_OUT(XOR16))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  crc_serial_engine #(.CRC_W(16), .DATA_W(8), .POLY(POLY16), .INIT(INIT_B), .XOR_OUT(XOR16))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  crc_serial_engine #(.CRC_W(32), .DATA_W(1), .POLY(POLY32), .INIT(INIT_C), .XOR_OUT(XOR_C))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  // Instance B sees exactly the same word stream as A.
  assign bus_b.in_valid = bus_a.in_valid;
  assign bus_b.in_data  = bus_a.in_data;
  assign bus_b.in_sop   = bus_a.in_sop;
  assign bus_b.in_eop   = bus_a.in_eop;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: CRC as polynomial division over the message bit stream.
  function automatic logic [63:0] mdl_word(input logic [63:0] crc, input logic [63:0] data,
                                           input int dw, input int cw, input logic [63:0] poly);
    logic [63:0] r;
    logic [63:0] mask;
    logic        top;
    r    = crc;
    mask = (cw == 64) ? '1 : ((64'd1 << cw) - 64'd1);
    for (int i = 0; i < dw; i++) begin
      top = r[cw-1] ^ data[REFLECT ? i : dw-1-i];
      r   = (r << 1) & mask;
      if (top) r = r ^ poly;
    end
    return r;
  endfunction

  function automatic logic [63:0] mdl_final(input logic [63:0] crc, input int cw, input logic [63:0] xo);
    logic [63:0] r;
    r = crc;
    if (REFLECT) begin
      r = '0;
      for (int i = 0; i < cw; i++) r[i] = crc[cw-1-i];
    end
    return r ^ xo;
  endfunction

  logic [63:0] run_a, run_b, run_c;
  logic [63:0] exp_a[$], exp_b[$], exp_c[$];
  logic [63:0] e_a, e_b, e_c;
  int acc_ab = 0;
  int acc_c  = 0;
  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  task automatic send_ab(input logic [7:0] d, input logic sop, input logic eop,
                         input bit hold, output int waited);
    @(negedge clk);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    bus_a.in_sop   = sop;
    bus_a.in_eop   = eop;
    waited = 0;
    while (!bus_a.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus_a.in_ready) begin
      check_eq("a_ready_timeout", bus_a.in_ready, 1);
    end else begin
      acc_ab = cyc;
      if (sop) begin run_a = INIT_A; run_b = INIT_B; end
      run_a = mdl_word(run_a, d, 8, 16, POLY16);
      run_b = mdl_word(run_b, d, 8, 16, POLY16);
      if (eop) begin
        exp_a.push_back(mdl_final(run_a, 16, XOR16));
        exp_b.push_back(mdl_final(run_b, 16, XOR16));
      end
      @(posedge clk);
    end
    if (!hold) begin
      #1;
      bus_a.in_valid = 1'b0;
    end
  endtask

  task automatic send_c(input logic d, input logic sop, input logic eop);
    int waited;
    @(negedge clk);
    bus_c.in_valid = 1'b1;
    bus_c.in_data  = d;
    bus_c.in_sop   = sop;
    bus_c.in_eop   = eop;
    waited = 0;
    while (!bus_c.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus_c.in_ready) begin
      check_eq("c_ready_timeout", bus_c.in_ready, 1);
    end else begin
      acc_c = cyc;
      if (sop) run_c = INIT_C;
      run_c = mdl_word(run_c, {63'd0, d}, 1, 32, POLY32);
      if (eop) exp_c.push_back(mdl_final(run_c, 32, XOR_C));
      @(posedge clk);
    end
    #1;
    bus_c.in_valid = 1'b0;
  endtask

  task automatic send_frame_ab(input bit hold);
    int w;
    for (int i = 0; i < 9; i++) begin
      send_ab(msg[i], i == 0, i == 8, hold && i != 8, w);
      if (hold && i > 0) check_eq($sformatf("hs_ready_low_%0d", i), w, 8);
    end
  endtask

  task automatic check_consts(input string tag);
    repeat (12) @(negedge clk);
    check_eq({tag, "_crc_a"}, bus_a.crc_out, K_A);
    check_eq({tag, "_crc_b"}, bus_b.crc_out, K_B);
    check_eq({tag, "_run_a"}, bus_a.crc_running, run_a);
  endtask

  // Scoreboard: every crc_valid pulse must match the next expected frame result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.crc_valid) begin
        if (exp_a.size() == 0) check_eq("a_spurious_valid", bus_a.crc_valid, 0);
        else begin
          e_a = exp_a.pop_front();
          $display("crc_a pulse: crc_out=%h expected=%h", bus_a.crc_out, e_a);
          check_eq("a_crc", bus_a.crc_out, e_a);
          check_eq("a_latency", 64'(cyc - acc_ab), 9);
        end
      end
      if (bus_b.crc_valid) begin
        if (exp_b.size() == 0) check_eq("b_spurious_valid", bus_b.crc_valid, 0);
        else begin
          e_b = exp_b.pop_front();
          $display("crc_b pulse: crc_out=%h expected=%h", bus_b.crc_out, e_b);
          check_eq("b_crc", bus_b.crc_out, e_b);
          check_eq("b_latency", 64'(cyc - acc_ab), 9);
        end
      end
      if (bus_c.crc_valid) begin
        if (exp_c.size() == 0) check_eq("c_spurious_valid", bus_c.crc_valid, 0);
        else begin
          e_c = exp_c.pop_front();
          $display("crc_c pulse: crc_out=%h expected=%h", bus_c.crc_out, e_c);
          check_eq("c_crc", bus_c.crc_out, e_c);
          check_eq("c_latency", 64'(cyc - acc_c), 2);
        end
      end
    end
  end

  initial begin
    int w, gap, len;
    bit hold;
    logic [7:0] d;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_sop = 1'b0; bus_a.in_eop = 1'b0;
    bus_c.in_valid = 1'b0; bus_c.in_data = '0; bus_c.in_sop = 1'b0; bus_c.in_eop = 1'b0;
    run_a = INIT_A; run_b = INIT_B; run_c = INIT_C;

    repeat (3) @(negedge clk);
    check_eq("rst_ready",   bus_a.in_ready, 0);
    check_eq("rst_busy",    bus_a.busy, 0);
    check_eq("rst_valid",   bus_a.crc_valid, 0);
    check_eq("rst_crc_out", bus_a.crc_out, 0);
    check_eq("rst_run_a",   bus_a.crc_running, INIT_A);
    check_eq("rst_run_b",   bus_b.crc_running, INIT_B);
    rst_n = 1'b1;

    // Check value, gaps between words.
    send_frame_ab(1'b0);
    check_consts("frame");

    // in_valid held high across the frame.
    send_frame_ab(1'b1);
    check_consts("held");

    // Abandoned partial frame restarted by a fresh sop.
    for (int i = 0; i < 4; i++) send_ab(8'($urandom), i == 0, 1'b0, 1'b0, w);
    send_frame_ab(1'b0);
    check_consts("resop");

    // Reset in the middle of word 5's shifting.
    for (int i = 0; i < 5; i++) send_ab(msg[i], i == 0, 1'b0, 1'b0, w);
    repeat (3) @(negedge clk);
    check_eq("mid_busy", bus_a.busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_ready",   bus_a.in_ready, 0);
    check_eq("mrst_busy",    bus_a.busy, 0);
    check_eq("mrst_valid",   bus_a.crc_valid, 0);
    check_eq("mrst_crc_out", bus_a.crc_out, 0);
    check_eq("mrst_crc_b",   bus_b.crc_out, 0);
    check_eq("mrst_run_a",   bus_a.crc_running, INIT_A);
    run_a = INIT_A; run_b = INIT_B; run_c = INIT_C;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame_ab(1'b0);
    check_consts("after_rst");

    // Randomised frames, gaps, held valid and occasional mid-frame sop.
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        gap  = $urandom_range(0, 2);
        hold = (gap == 0) && (i != len - 1);
        d    = 8'($urandom);
        send_ab(d, (i == 0) || ($urandom_range(0, 7) == 0), i == len - 1, hold, w);
        if (!hold) repeat (gap) @(negedge clk);
      end
    end
    repeat (12) @(negedge clk);
    check_eq("rand_run_a", bus_a.crc_running, run_a);
    check_eq("rand_run_b", bus_b.crc_running, run_b);

    // DATA_W=1 instance, CRC-32, bytes fed one bit per word.
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8; j++)
        send_c(msg[i][REFLECT ? j : 7-j], (i == 0) && (j == 0), (i == 8) && (j == 7));
    repeat (4) @(negedge clk);
    check_eq("crc32_const", bus_c.crc_out, K_C);

    repeat (4) @(negedge clk);
    check_eq("pending_a", exp_a.size(), 0);
    check_eq("pending_b", exp_b.size(), 0);
    check_eq("pending_c", exp_c.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
